// File: rtl/ca3_q4_popcount_sequencer_if.sv
// ca3_q4_popcount_sequencer_if: word stream in, total popcount result out
interface ca3_q4_popcount_sequencer_if #(
  parameter int WORDS = 4,
  parameter int ACC_W = $clog2(WORDS*127+1)
);
  logic             start;
  logic [126:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] count;
  logic             above;
  modport master (output start, in_data, in_valid, input in_ready, busy, done, count, above);
  modport slave (input start, in_data, in_valid, output in_ready, busy, done, count, above);
endinterface

// File: rtl/ca3_q4_popcount_sequencer.sv
// ca3_q4_popcount_sequencer: sums the ones of WORDS 127-bit chunks through one shared counter
module ca3_q4_ones127 (
  input  logic [126:0] d_i,
  output logic         co_o,
  output logic [5:0]   sum_o
);
  logic [6:0] n;
  // plain adder chain over all 127 bits; synthesis turns this into a compressor tree
  always_comb begin
    n = '0;
    for (int i = 0; i < 127; i++) n = n + 7'(d_i[i]);
  end
  assign {co_o, sum_o} = n;
endmodule

module ca3_q4_popcount_sequencer #(
  parameter int WORDS  = 4,
  parameter int ACC_W  = $clog2(WORDS*127+1),
  parameter int THRESH = 254
) (
  input logic clk,
  input logic rst,
  ca3_q4_popcount_sequencer_if.slave bus
);
  localparam int CW = $clog2(WORDS+1);
  localparam int unsigned TH = THRESH;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, count_q, count_d, fin;
  logic [6:0]       pc_q, pc_d;
  logic             pc_v_q, pc_v_d, above_q, above_d;
  logic [CW-1:0]    word_cnt_q, word_cnt_d;
  logic             co, hs, go;
  logic [5:0]       sum;
  ca3_q4_ones127 u_ones (.d_i(bus.in_data), .co_o(co), .sum_o(sum));
  assign hs  = bus.in_valid && state_q == LOAD;
  assign go  = bus.start && state_q == IDLE;
  assign fin = acc_q + (pc_v_q ? ACC_W'(pc_q) : '0);
  assign bus.in_ready = state_q == LOAD;
  assign bus.busy     = state_q != IDLE;
  assign bus.done     = state_q == DONE;
  assign bus.count    = count_q;
  assign bus.above    = above_q;
  // sequence: wait for start, take WORDS chunks, one cycle to fold in the last count, pulse done
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.start ? LOAD : IDLE;
      LOAD:    state_d = hs && word_cnt_q == CW'(WORDS-1) ? DRAIN : LOAD;
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // chunk counts are registered one cycle before they are folded into acc
  always_comb begin
    pc_d       = hs ? {co, sum} : pc_q;
    pc_v_d     = hs;
    word_cnt_d = go ? '0 : hs ? word_cnt_q + CW'(1) : word_cnt_q;
    acc_d      = go ? '0 : fin;
    count_d    = state_q == DRAIN ? fin : count_q;
    above_d    = state_q == DRAIN ? 32'(fin) > TH : above_q;
  end
  // state and datapath registers, reset aborts any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      pc_q       <= '0;
      pc_v_q     <= 1'b0;
      word_cnt_q <= '0;
      count_q    <= '0;
      above_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pc_q       <= pc_d;
      pc_v_q     <= pc_v_d;
      word_cnt_q <= word_cnt_d;
      count_q    <= count_d;
      above_q    <= above_d;
    end
  end
endmodule
